cla_seq_adder: RTL and testbench

Nibble-serial wide adder controller that sequences the team's existing 4-bit `cla` slice to add two WIDTH-bit operands, one nibble per clock. Operands are latched on a start pulse, the carry is registered between nibbles, and the full sum is published with a one-cycle done pulse. Used wherever a wide add is needed but area matters more than latency; the single `cla` instance is the only arithmetic resource.

---
 rtl/cla_seq_pkg.sv | 18 +
 rtl/cla_seq_adder_cla.sv | 29 ++
 rtl/cla_seq_adder.sv | 164 ++++++++++++++++
 tb/tb_cla_seq_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding,
// slice width, and the step-counter width helper.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NIB_W = 4;

    // A single-nibble adder still needs a 1-bit counter to stay legal.
    function automatic int unsigned step_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_cla.sv
// Existing 4-bit carry-lookahead slice, shared by the nibble-serial adder.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit adder driving one shared 4-bit cla slice.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIB    = WIDTH / NIB_W;
    localparam int unsigned STEP_W = step_width(NIB);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIB - 1);

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef CLA_SEQ_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic [NIB_W-1:0]   nib_sum;
    logic               nib_cout;
    logic               accept;

    cla u_cla (
        .a    (a_sh_q[NIB_W-1:0]),
        .b    (b_sh_q[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        accept  = 1'b0;
`ifdef CLA_SEQ_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                acc_d[int'(step_q) * NIB_W +: NIB_W] = nib_sum;
                carry_d = nib_cout;
                a_sh_d  = a_sh_q >> NIB_W;
                b_sh_d  = b_sh_q >> NIB_W;
                step_d  = step_q + 1'b1;
                // Publish acc_d, not acc_q, so the final nibble lands in the same edge.
                if (step_q == LAST_STEP) begin
                    sum_d   = acc_d;
                    cout_d  = nib_cout;
                    done_d  = 1'b1;
                    step_d  = '0;
                    state_d = DONE;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (nib_sum[NIB_W-1] != a_msb_q);
`endif
                end
            end
            DONE: begin
                accept  = start;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            step_d  = '0;
            acc_d   = '0;
            state_d = RUN;
`ifdef CLA_SEQ_OVF_EN
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
`endif
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CLA_SEQ_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=16); ovf checks compile in with CLA_SEQ_OVF_EN.
module tb_cla_seq_adder;

    localparam int unsigned WIDTH = 16;
    localparam int LATENCY = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands at a non-edge time; returns just after the accepting edge.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
    endtask

    // Count cycles to done; optionally pulse start with junk operands mid-RUN.
    task automatic wait_done(input vec_t v, input string name, input int glitch_cyc);
        int  cyc;
        bit  seen;
        bit  busy_bad;
        cyc      = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == glitch_cyc) begin
                start = 1'b1;
                a     = 16'h1111;
                b     = 16'h2222;
                cin   = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
            else if (!busy) busy_bad = 1'b1;
        end
        start = 1'b0;
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(LATENCY));
        check({name, " busy_during_run"}, 32'(busy_bad), 32'd0);
        check({name, " busy_with_done"}, 32'(busy), 32'd0);
        check({name, " sum"}, 32'(sum), 32'(v.exp_sum));
        check({name, " cout"}, 32'(cout), 32'(v.exp_cout));
`ifdef CLA_SEQ_OVF_EN
        check({name, " ovf"}, 32'(ovf), 32'(v.exp_ovf));
`endif
    endtask

    vec_t vecs[12];
    vec_t hv;
    bit   done_seen;

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[4]  = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1};
        vecs[10] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[11] = '{16'h1234, 16'hEDCB, 1'b0, 16'hFFFF, 1'b0, 1'b0};

        // Reset with start asserted and random operands.
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        check("reset ovf", 32'(ovf), 32'd0);
`endif
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(vecs[i], $sformatf("vec%0d", i), 0);
            @(negedge clk);
            check($sformatf("vec%0d done_pulse_width", i), 32'(done), 32'd0);
            check($sformatf("vec%0d sum_held", i), 32'(sum), 32'(vecs[i].exp_sum));
        end

        // Back-to-back: start again in the DONE cycle, with an ignored start mid-RUN.
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done(vecs[1], "b2b_first", 0);
        issue(16'hA5A5, 16'h5A5A, 1'b1);
        wait_done(vecs[4], "b2b_second", 2);
        @(negedge clk);
        check("b2b no_extra_run", 32'(busy), 32'd0);

        // Abort: reset during the second RUN cycle after a nonzero result.
        @(negedge clk);
        issue(16'h0F0F, 16'h00F1, 1'b1);
        wait_done(vecs[6], "pre_abort", 0);
        @(negedge clk);
        issue(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        check("abort busy_run1", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        done_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("abort no_done", 32'(done_seen), 32'd0);

        hv = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        issue(hv.a, hv.b, hv.cin);
        wait_done(hv, "post_abort", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
